// File: rtl/circ_fifo_pkg.sv
// Shared constants and types for the circular FIFO and its link.
package circ_fifo_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned DEPTH_LOG2 = 2;

    typedef logic [WORD_W-1:0] word_t;

endpackage : circ_fifo_pkg

// File: rtl/circ_fifo_if.sv
// FIFO link between a producer/consumer (master) and the FIFO (slave).
interface circ_fifo_if
    import circ_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = DEPTH_LOG2
);

    logic             read;
    logic             write;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic             empty;
    logic             full;
    logic [DEPTH:0]   count;

    modport master (
        output read,
        output write,
        output datain,
        input  dataout,
        input  empty,
        input  full,
        input  count
    );

    modport slave (
        input  read,
        input  write,
        input  datain,
        output dataout,
        output empty,
        output full,
        output count
    );

endinterface : circ_fifo_if

// File: rtl/circ_fifo_mem.sv
// Storage array for circ_fifo: one synchronous write port, one combinational read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned ENTRIES = 2 ** DEPTH;

    logic [WIDTH-1:0] mem [ENTRIES];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/circ_fifo.sv
// Single-clock FIFO with a circular mode in which reads rotate words back to the tail.
module circ_fifo
    import circ_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = DEPTH_LOG2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       circular,
    circ_fifo_if.slave link
);

    localparam int unsigned CAP = 2 ** DEPTH;

    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH:0]   count_q,  count_d;
    logic [WIDTH-1:0] dout_q,   dout_d;

    logic             is_empty;
    logic             is_full;
    logic             rd_ok;
    logic             wr_ok;
    logic             rotate;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (DEPTH+1)'(CAP));

    // Qualify requests and compute next pointer/count/data state.
    always_comb begin
        rd_ok     = 1'b0;
        wr_ok     = 1'b0;
        rotate    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = link.datain;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;

        rd_ok  = link.read & ~is_empty;
        rotate = circular & rd_ok;
        if (circular) begin
            // Rotation wins over a same-cycle write.
            wr_ok = link.write & ~is_full & ~rd_ok;
        end else begin
            wr_ok = link.write & (~is_full | rd_ok);
        end

        mem_we    = (wr_ok | rotate) & ~reset;
        mem_wdata = rotate ? mem_rdata : link.datain;

        rd_ptr_d = rd_ptr_q + DEPTH'(rd_ok);
        wr_ptr_d = wr_ptr_q + DEPTH'(wr_ok | rotate);
        count_d  = count_q + (DEPTH+1)'(wr_ok) - (DEPTH+1)'(rd_ok & ~circular);

        if (rd_ok) begin
            dout_d = mem_rdata;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign link.dataout = dout_q;
    assign link.count   = count_q;
    assign link.empty   = is_empty;
    assign link.full    = is_full;

endmodule : circ_fifo

// File: tb/tb_circ_fifo.sv
// Directed bench for circ_fifo: queue-based reference model plus literal spot checks.
module tb_circ_fifo;
    import circ_fifo_pkg::*;

    localparam int unsigned CAP = 2 ** DEPTH_LOG2;

    logic clk;
    logic reset;
    logic circular;

    circ_fifo_if link ();

    circ_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .circular (circular),
        .link     (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a queue, head = oldest word.
    word_t q[$];
    word_t m_dout;
    bit    m_valid = 1'b0;

    // Model update at each active edge from the inputs applied before it.
    always @(posedge clk) begin
        bit    rd;
        bit    wr;
        word_t w;
        if (reset) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            rd = link.read && (q.size() > 0);
            if (circular) begin
                if (rd) begin
                    w      = q.pop_front();
                    m_dout = w;
                    q.push_back(w);
                end else if (link.write && q.size() < CAP) begin
                    q.push_back(link.datain);
                end
            end else begin
                wr = link.write && ((q.size() < CAP) || rd);
                if (rd) m_dout = q.pop_front();
                if (wr) q.push_back(link.datain);
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle after first reset.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (link.dataout !== m_dout || link.count !== 3'(q.size()) ||
                link.empty !== (q.size() == 0) || link.full !== (q.size() == CAP)) begin
                failures++;
                $display("FAIL model t=%0t dataout=%h/%h count=%0d/%0d empty=%b/%b full=%b/%b",
                         $time, link.dataout, m_dout, link.count, q.size(),
                         link.empty, (q.size() == 0), link.full, (q.size() == CAP));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply inputs (called at a falling edge), then wait through the next active edge.
    task automatic tick(input bit rst, input bit c, input bit r, input bit w, input word_t d);
        reset       = rst;
        circular    = c;
        link.read   = r;
        link.write  = w;
        link.datain = d;
        @(negedge clk);
    endtask

    word_t rot[3];

    initial begin
        rot[0] = 32'hA; rot[1] = 32'hE; rot[2] = 32'h47F;
        reset = 1'b1; circular = 1'b0;
        link.read = 1'b0; link.write = 1'b0; link.datain = '0;

        // Reset held two cycles with reads asserted.
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        chk("rst_empty", 32'(link.empty), 32'd1);
        chk("rst_full", 32'(link.full), 32'd0);
        chk("rst_count", 32'(link.count), 32'd0);
        chk("rst_dout", link.dataout, 32'd0);

        // Read+write on empty: write stored, no bypass.
        tick(0, 0, 1, 1, 32'd9);
        chk("rw_empty_count", 32'(link.count), 32'd1);
        chk("rw_empty_dout", link.dataout, 32'd0);
        tick(0, 0, 1, 1, 32'd1);
        chk("rw_one_dout", link.dataout, 32'd9);
        chk("rw_one_count", 32'(link.count), 32'd1);
        tick(0, 0, 1, 0, 0);
        chk("rd_last_dout", link.dataout, 32'd1);
        chk("rd_last_empty", 32'(link.empty), 32'd1);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("rd_on_empty_hold", link.dataout, 32'd1);

        // Fill to full, then one dropped write.
        tick(0, 0, 0, 1, 32'hA);
        tick(0, 0, 0, 1, 32'hE);
        tick(0, 0, 0, 1, 32'h47F);
        tick(0, 0, 0, 1, 32'h5);
        chk("fill_full", 32'(link.full), 32'd1);
        tick(0, 0, 0, 1, 32'h6);
        chk("drop_count", 32'(link.count), 32'd4);
        // Read+write on full: both happen, still full.
        tick(0, 0, 1, 1, 32'h7);
        chk("rw_full_dout", link.dataout, 32'hA);
        chk("rw_full_count", 32'(link.count), 32'd4);
        tick(0, 0, 1, 0, 0); chk("drain0", link.dataout, 32'hE);
        tick(0, 0, 1, 0, 0); chk("drain1", link.dataout, 32'h47F);
        tick(0, 0, 1, 0, 0); chk("drain2", link.dataout, 32'h5);
        tick(0, 0, 1, 0, 0); chk("drain3", link.dataout, 32'h7);
        tick(0, 0, 1, 0, 0);
        chk("drain_empty", 32'(link.empty), 32'd1);
        chk("drain_hold", link.dataout, 32'h7);

        // Three words rotating for 12 reads.
        tick(0, 0, 0, 1, 32'hA);
        tick(0, 0, 0, 1, 32'hE);
        tick(0, 0, 0, 1, 32'h47F);
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 1, 0, 0);
            chk("rot_dout", link.dataout, rot[i % 3]);
            chk("rot_count", 32'(link.count), 32'd3);
        end

        // Write during rotation dropped; then a write without read lands at tail.
        tick(0, 1, 1, 1, 32'h0);
        chk("rot_wdrop_dout", link.dataout, 32'hA);
        chk("rot_wdrop_count", 32'(link.count), 32'd3);
        tick(0, 1, 0, 1, 32'h0);
        chk("rot_w_count", 32'(link.count), 32'd4);
        chk("rot_w_full", 32'(link.full), 32'd1);
        tick(0, 1, 1, 0, 0); chk("rot4_0", link.dataout, 32'hE);
        tick(0, 1, 1, 0, 0); chk("rot4_1", link.dataout, 32'h47F);
        tick(0, 1, 1, 0, 0); chk("rot4_2", link.dataout, 32'hA);
        tick(0, 1, 1, 0, 0); chk("rot4_3", link.dataout, 32'h0);
        tick(0, 1, 1, 0, 0); chk("rot4_4", link.dataout, 32'hE);

        // Back to normal mode mid-stream: consumes from current head, no flush.
        tick(0, 0, 1, 0, 0);
        chk("mode_sw_dout", link.dataout, 32'h47F);
        chk("mode_sw_count", 32'(link.count), 32'd3);

        // Reset during circular rotation.
        tick(0, 1, 1, 0, 0);
        tick(1, 1, 1, 1, 32'h55);
        chk("mid_rst_count", 32'(link.count), 32'd0);
        chk("mid_rst_empty", 32'(link.empty), 32'd1);
        chk("mid_rst_dout", link.dataout, 32'd0);
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("post_rst_rd_ignored", link.dataout, 32'd0);
        tick(0, 1, 0, 1, 32'h123);
        chk("post_rst_write", 32'(link.count), 32'd1);
        tick(0, 1, 1, 0, 0);
        chk("post_rst_rot", link.dataout, 32'h123);
        tick(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_circ_fifo
